rasterize_stream: RTL

- Parametrised sequential successor to the combinational rectangle rasterizer.
- Latches three vertices and a shape mode on a start handshake, then scans the WIDTH x HEIGHT pixel grid at one pixel per accepted beat.
- Streams per-pixel coverage over valid/ready and accumulates the coverage into a screen bitmap.
- Sits between the shape front end and the display/framebuffer writer; adds triangle coverage and backpressure.

---
 rtl/raster_pkg.sv | 25 ++
 rtl/raster_coverage.sv | 76 +++++++
 rtl/rasterize_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared definitions for the streaming rasterizer.
//   state_e      : scan FSM states (IDLE, SCAN, DONE)
//   SHAPE_*      : shape mode encodings on the 'shape' input
//   diff_width   : signed width that holds any coordinate difference
//   edge_width   : signed width that holds an edge-function result without overflow
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic SHAPE_RECT = 1'b0;
    localparam logic SHAPE_TRI  = 1'b1;

    function automatic int diff_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 1;
    endfunction

    function automatic int edge_width(input int xw, input int yw);
        return 2 * diff_width(xw, yw) + 1;
    endfunction

endpackage

// File: rtl/raster_coverage.sv
// Combinational single-pixel coverage test.
//   a_x/a_y, b_x/b_y, c_x/c_y : vertices (unsigned)
//   shape                     : SHAPE_RECT or SHAPE_TRI
//   x, y                      : pixel under test
//   on                        : pixel covered
// Rectangle uses A as the min corner, B.x as max x and C.y as max y.
// Triangle uses three edge functions with inclusive edges; either winding
// is accepted and a zero-area triangle covers nothing.
module raster_coverage
    import raster_pkg::*;
#(
    parameter int XW = 2,
    parameter int YW = 2
) (
    input  logic [XW-1:0] a_x,
    input  logic [YW-1:0] a_y,
    input  logic [XW-1:0] b_x,
    input  logic [YW-1:0] b_y,
    input  logic [XW-1:0] c_x,
    input  logic [YW-1:0] c_y,
    input  logic          shape,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          on
);

    localparam int DW = diff_width(XW, YW);
    localparam int EW = edge_width(XW, YW);

    // Zero-extend unsigned coordinates into the signed difference domain.
    function automatic logic signed [DW-1:0] sx(input logic [XW-1:0] v);
        return signed'({{(DW-XW){1'b0}}, v});
    endfunction

    function automatic logic signed [DW-1:0] sy(input logic [YW-1:0] v);
        return signed'({{(DW-YW){1'b0}}, v});
    endfunction

    // E(P0,P1,Q) = (P1.x-P0.x)*(Q.y-P0.y) - (P1.y-P0.y)*(Q.x-P0.x)
    function automatic logic signed [EW-1:0] edge_fn(
        input logic signed [DW-1:0] p0x, input logic signed [DW-1:0] p0y,
        input logic signed [DW-1:0] p1x, input logic signed [DW-1:0] p1y,
        input logic signed [DW-1:0] qx,  input logic signed [DW-1:0] qy
    );
        logic signed [DW-1:0] d1x, d1y, dqx, dqy;
        logic signed [EW-1:0] e1x, e1y, eqx, eqy;
        d1x = p1x - p0x;
        d1y = p1y - p0y;
        dqx = qx - p0x;
        dqy = qy - p0y;
        // Sign-extend before multiplying so the products keep full precision.
        e1x = d1x;
        e1y = d1y;
        eqx = dqx;
        eqy = dqy;
        return e1x * eqy - e1y * eqx;
    endfunction

    logic signed [EW-1:0] area, e_ab, e_bc, e_ca;
    logic                 rect_on, tri_on;

    always_comb begin
        area = edge_fn(sx(a_x), sy(a_y), sx(b_x), sy(b_y), sx(c_x), sy(c_y));
        e_ab = edge_fn(sx(a_x), sy(a_y), sx(b_x), sy(b_y), sx(x), sy(y));
        e_bc = edge_fn(sx(b_x), sy(b_y), sx(c_x), sy(c_y), sx(x), sy(y));
        e_ca = edge_fn(sx(c_x), sy(c_y), sx(a_x), sy(a_y), sx(x), sy(y));

        rect_on = (y >= a_y) && (y <= c_y) && (x >= a_x) && (x <= b_x);

        tri_on = ((area > 0) && (e_ab >= 0) && (e_bc >= 0) && (e_ca >= 0)) ||
                 ((area < 0) && (e_ab <= 0) && (e_bc <= 0) && (e_ca <= 0));

        on = (shape == SHAPE_TRI) ? tri_on : rect_on;
    end

endmodule

// File: rtl/rasterize_stream.sv
// Streaming rasterizer: latches a rectangle or triangle on start, then
// walks the WIDTH x HEIGHT grid in raster order (x fastest), one pixel per
// accepted beat, and accumulates coverage into a screen bitmap.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a scan (ignored while busy)
//   coord*_X/Y, shape   : vertices and shape mode, sampled on start
//   busy                : scan in progress, including the done cycle
//   pix_valid/pix_ready : pixel stream handshake
//   pix_x/pix_y/pix_on  : current pixel and its coverage
//   pix_last            : current pixel is (WIDTH-1, HEIGHT-1)
//   done                : one-cycle pulse after the last beat
//   screen              : coverage bitmap, bit y*WIDTH+x
module rasterize_stream
    import raster_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 3,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [XW-1:0]           coordA_X,
    input  logic [XW-1:0]           coordB_X,
    input  logic [XW-1:0]           coordC_X,
    input  logic [YW-1:0]           coordA_Y,
    input  logic [YW-1:0]           coordB_Y,
    input  logic [YW-1:0]           coordC_Y,
    input  logic                    shape,
    output logic                    busy,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [XW-1:0]           pix_x,
    output logic [YW-1:0]           pix_y,
    output logic                    pix_on,
    output logic                    pix_last,
    output logic                    done,
    output logic [WIDTH*HEIGHT-1:0] screen
);

    localparam int NPIX = WIDTH * HEIGHT;

    state_e        state, state_nxt;
    logic [XW-1:0] a_x, b_x, c_x, x_cnt;
    logic [YW-1:0] a_y, b_y, c_y, y_cnt;
    logic          shp;
    logic          cov_on;
    logic          at_last, x_wrap, accept, hs;
    int            pix_idx;

    raster_coverage #(.XW(XW), .YW(YW)) u_cov (
        .a_x   (a_x),
        .a_y   (a_y),
        .b_x   (b_x),
        .b_y   (b_y),
        .c_x   (c_x),
        .c_y   (c_y),
        .shape (shp),
        .x     (x_cnt),
        .y     (y_cnt),
        .on    (cov_on)
    );

    assign x_wrap  = (x_cnt == XW'(WIDTH - 1));
    assign at_last = x_wrap && (y_cnt == YW'(HEIGHT - 1));
    assign pix_idx = int'(y_cnt) * WIDTH + int'(x_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        pix_valid = 1'b0;
        pix_on    = 1'b0;
        pix_last  = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        hs        = 1'b0;
        pix_x     = x_cnt;
        pix_y     = y_cnt;
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                // Latched vertices reset to a valid rectangle at (0,0), so
                // coverage must be gated to keep pix_on low outside SCAN.
                pix_on    = cov_on;
                pix_last  = at_last;
                hs        = pix_ready;
                if (pix_ready && at_last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_x    <= '0;
            b_x    <= '0;
            c_x    <= '0;
            a_y    <= '0;
            b_y    <= '0;
            c_y    <= '0;
            shp    <= SHAPE_RECT;
            x_cnt  <= '0;
            y_cnt  <= '0;
            screen <= '0;
        end else if (accept) begin
            a_x    <= coordA_X;
            b_x    <= coordB_X;
            c_x    <= coordC_X;
            a_y    <= coordA_Y;
            b_y    <= coordB_Y;
            c_y    <= coordC_Y;
            shp    <= shape;
            x_cnt  <= '0;
            y_cnt  <= '0;
            screen <= '0;
        end else if (hs) begin
            for (int i = 0; i < NPIX; i++) begin
                if (i == pix_idx) screen[i] <= cov_on;
            end
            if (x_wrap) begin
                x_cnt <= '0;
                // Leave the counter at (0,0) after the final pixel.
                y_cnt <= at_last ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

endmodule
